// File: rtl/jls_stream_packer.sv
// Packs the jls_encoder byte stream into little-endian 32-bit words and buffers them in a
// word FIFO behind a valid/ready port. Optional byte counter: define JLS_PACK_BYTECNT_EN.
module jls_stream_packer #(
   parameter int AW          = 6,
   parameter int ALMOST_FULL = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ivalid,
   input  logic        ilast,
   input  logic        ierror,
   input  logic [7:0]  idata,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_data,
   output logic [3:0]  m_keep,
   output logic        m_last,
   output logic        m_error,
   output logic        ofull_warn,
`ifdef JLS_PACK_BYTECNT_EN
   output logic [31:0] obytes,
   output logic        obytes_valid,
`endif
   output logic        ooverflow
);

   localparam int DEPTH = 2**AW;

   // Packer state
   logic [1:0]  r_bi;
   logic [31:0] r_asm;
   logic [31:0] w_word;
   logic [3:0]  w_keep;
   logic        w_push;
   logic [37:0] w_entry;

   // FIFO state: r_mcount counts words in memory not yet moved to the output stage
   logic [37:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_mcount;
   logic          r_m_valid;
   logic [31:0]   r_m_data;
   logic [3:0]    r_m_keep;
   logic          r_m_last;
   logic          r_m_error;
   logic          r_full_warn;
   logic          r_overflow;

   logic [AW:0]   w_total;
   logic          w_full;
   logic          w_pop;
   logic          w_push_ok;
   logic          w_load;
   logic [AW:0]   w_mcount_nxt;
   logic          w_mvalid_nxt;
   logic [AW:0]   w_total_nxt;
   logic [31:0]   w_free_nxt;
   logic [37:0]   w_head;

   always_comb begin
      w_word = r_asm;
      w_word[{r_bi, 3'b000} +: 8] = idata;
   end

   always_comb begin
      w_keep = 4'b1111;
      if (ilast) begin
         case (r_bi)
            2'd0:    w_keep = 4'b0001;
            2'd1:    w_keep = 4'b0011;
            2'd2:    w_keep = 4'b0111;
            default: w_keep = 4'b1111;
         endcase
      end
   end

   assign w_push  = ivalid & ((r_bi == 2'd3) | ilast);
   assign w_entry = {ilast & ierror, ilast, w_keep, w_word};

   // The assembly register is cleared on every push so unused lanes of a short last word read 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bi  <= 2'd0;
         r_asm <= 32'd0;
      end else if (ivalid) begin
         if (w_push) begin
            r_bi  <= 2'd0;
            r_asm <= 32'd0;
         end else begin
            r_bi  <= r_bi + 2'd1;
            r_asm <= w_word;
         end
      end
   end

   // Capacity includes the word held in the output stage
   assign w_total      = r_mcount + {{AW{1'b0}}, r_m_valid};
   assign w_full       = (w_total == (AW+1)'(DEPTH));
   assign w_pop        = r_m_valid & m_ready;
   assign w_push_ok    = w_push & (~w_full | w_pop);
   assign w_load       = (~r_m_valid | w_pop) & (r_mcount != '0);
   assign w_mcount_nxt = r_mcount + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_load};
   assign w_mvalid_nxt = w_load | (r_m_valid & ~w_pop);
   assign w_total_nxt  = w_mcount_nxt + {{AW{1'b0}}, w_mvalid_nxt};
   assign w_free_nxt   = 32'(DEPTH) - 32'(w_total_nxt);
   assign w_head       = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= w_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_mcount    <= '0;
         r_m_valid   <= 1'b0;
         r_m_data    <= 32'd0;
         r_m_keep    <= 4'd0;
         r_m_last    <= 1'b0;
         r_m_error   <= 1'b0;
         r_full_warn <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_load) begin
            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_m_data  <= w_head[31:0];
            r_m_keep  <= w_head[35:32];
            r_m_last  <= w_head[36];
            r_m_error <= w_head[37];
         end
         if (w_push & ~w_push_ok) begin
            r_overflow <= 1'b1;
         end
         r_mcount    <= w_mcount_nxt;
         r_m_valid   <= w_mvalid_nxt;
         r_full_warn <= (w_free_nxt <= 32'(ALMOST_FULL));
      end
   end

   assign m_valid    = r_m_valid;
   assign m_data     = r_m_data;
   assign m_keep     = r_m_keep;
   assign m_last     = r_m_last;
   assign m_error    = r_m_error;
   assign ofull_warn = r_full_warn;
   assign ooverflow  = r_overflow;

`ifdef JLS_PACK_BYTECNT_EN
   logic [31:0] r_bcnt;
   logic [31:0] r_obytes;
   logic        r_obytes_valid;

   // Counts every accepted byte strobe, including bytes of words the FIFO dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bcnt         <= 32'd0;
         r_obytes       <= 32'd0;
         r_obytes_valid <= 1'b0;
      end else begin
         r_obytes_valid <= 1'b0;
         if (ivalid) begin
            if (ilast) begin
               r_obytes       <= r_bcnt + 32'd1;
               r_obytes_valid <= 1'b1;
               r_bcnt         <= 32'd0;
            end else begin
               r_bcnt <= r_bcnt + 32'd1;
            end
         end
      end
   end

   assign obytes       = r_obytes;
   assign obytes_valid = r_obytes_valid;
`endif

endmodule
